// File: rtl/fma_issue_ctrl_pkg.sv
// Shared constants and FSM encoding for the FMA issue controller.
// Operand geometry mirrors the single-precision core defaults.
package fma_issue_ctrl_pkg;
    localparam int FMA_WIDTH     = 32;
    localparam int FMA_EXP_WIDTH = 8;
    localparam int FMA_SIG_WIDTH = 23;
    localparam int FMA_LATENCY   = 4;

    // TAIL is the second, non-issuing cycle a subnormal triple owns the core port
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2,
        TAIL  = 2'd3
    } state_t;
endpackage

// File: rtl/fma_issue_ctrl_if.sv
// Requester, core-launch and result-return signals of the FMA issue controller.
// slave is the controller side; master is the requester/core side.
interface fma_issue_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req1_valid;
    logic             req0_ready;
    logic             req1_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [WIDTH-1:0] req0_c;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [WIDTH-1:0] req1_c;
    logic             fma_issue;
    logic [WIDTH-1:0] fma_a;
    logic [WIDTH-1:0] fma_b;
    logic [WIDTH-1:0] fma_c;
    logic [2:0]       fma_sub;
    logic [WIDTH-1:0] fma_res;
    logic             res_valid;
    logic             res_id;
    logic [WIDTH-1:0] res_data;

    modport slave (
        input  req0_valid, req1_valid,
        input  req0_a, req0_b, req0_c, req1_a, req1_b, req1_c,
        input  fma_res,
        output req0_ready, req1_ready,
        output fma_issue, fma_a, fma_b, fma_c, fma_sub,
        output res_valid, res_id, res_data
    );

    modport master (
        output req0_valid, req1_valid,
        output req0_a, req0_b, req0_c, req1_a, req1_b, req1_c,
        output fma_res,
        input  req0_ready, req1_ready,
        input  fma_issue, fma_a, fma_b, fma_c, fma_sub,
        input  res_valid, res_id, res_data
    );
endinterface

// File: rtl/fma_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins outright, contention is
// resolved by rr_ptr, which then points at the loser of each handshake.
module fma_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] valid,
    output logic [1:0] grant
);
    logic rr_ptr_reg;

    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (valid == 2'b11) begin
                grant = rr_ptr_reg ? 2'b10 : 2'b01;
            end else begin
                grant = valid;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg <= 1'b0;
        end else if (|grant) begin
            rr_ptr_reg <= grant[0];
        end
    end
endmodule

// File: rtl/fma_unpack.sv
// Splits a floating-point operand into exponent and significand (hidden bit
// restored) and flags subnormals: zero exponent with a nonzero fraction.
module fma_unpack #(
    parameter int WIDTH     = 32,
    parameter int EXP_WIDTH = 8,
    parameter int SIG_WIDTH = 23
) (
    input  logic [WIDTH-1:0]     operand,
    output logic [EXP_WIDTH-1:0] exp,
    output logic [SIG_WIDTH:0]   sig,
    output logic                 sub
);
    logic unused_sign;

    assign exp         = operand[SIG_WIDTH +: EXP_WIDTH];
    assign sig         = {|exp, operand[SIG_WIDTH-1:0]};
    assign sub         = (exp == '0) && (operand[SIG_WIDTH-1:0] != '0);
    assign unused_sign = operand[WIDTH-1];
endmodule

// File: rtl/fma_issue_ctrl.sv
// Arbitrates two operand-triple requesters onto a fixed-latency FMA core,
// stretching subnormal triples to two port cycles and routing results back by tag.
module fma_issue_ctrl
    import fma_issue_ctrl_pkg::*;
#(
    parameter int WIDTH     = FMA_WIDTH,
    parameter int EXP_WIDTH = FMA_EXP_WIDTH,
    parameter int SIG_WIDTH = FMA_SIG_WIDTH,
    parameter int LATENCY   = FMA_LATENCY
) (
    input  logic            clk,
    input  logic            rst_n,
    fma_issue_ctrl_if.slave bus
);
    state_t               state_reg;
    state_t               state_next;
    logic                 arb_en;
    logic                 issue;
    logic                 handshake;
    logic [1:0]           valid;
    logic [1:0]           grant;
    logic [WIDTH-1:0]     opnd [3];
    logic [EXP_WIDTH-1:0] unp_exp [3];
    logic [SIG_WIDTH:0]   unp_sig [3];
    logic [2:0]           sub_flag;
    logic [2:0]           sub_vec;
    logic                 unused_fields;
    logic [WIDTH-1:0]     a_reg;
    logic [WIDTH-1:0]     b_reg;
    logic [WIDTH-1:0]     c_reg;
    logic [2:0]           sub_reg;
    logic                 tag_reg;
    logic [LATENCY-1:0]   pipe_valid_reg;
    logic [LATENCY-1:0]   pipe_id_reg;

    // Readies are forced low during reset even though they are combinational
    assign arb_en    = rst_n && ((state_reg == IDLE) || (state_reg == ISSUE));
    assign valid     = {bus.req1_valid, bus.req0_valid};
    assign handshake = |grant;

    fma_rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (arb_en),
        .valid (valid),
        .grant (grant)
    );

    assign bus.req0_ready = grant[0];
    assign bus.req1_ready = grant[1];

    assign opnd[0] = grant[1] ? bus.req1_a : bus.req0_a;
    assign opnd[1] = grant[1] ? bus.req1_b : bus.req0_b;
    assign opnd[2] = grant[1] ? bus.req1_c : bus.req0_c;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_unpack
            fma_unpack #(
                .WIDTH     (WIDTH),
                .EXP_WIDTH (EXP_WIDTH),
                .SIG_WIDTH (SIG_WIDTH)
            ) u_unpack (
                .operand (opnd[gi]),
                .exp     (unp_exp[gi]),
                .sig     (unp_sig[gi]),
                .sub     (sub_flag[gi])
            );
        end
    endgenerate

    // Only the subnormal flags matter here; exponent/significand are for the core
    assign unused_fields = ^{unp_exp[0], unp_exp[1], unp_exp[2],
                             unp_sig[0], unp_sig[1], unp_sig[2]};
    assign sub_vec = {sub_flag[0], sub_flag[1], sub_flag[2]};

    always_comb begin
        state_next = IDLE;
        issue      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (handshake) state_next = (|sub_vec) ? HOLD : ISSUE;
            end
            ISSUE: begin
                issue = 1'b1;
                if (handshake) state_next = (|sub_vec) ? HOLD : ISSUE;
            end
            HOLD: begin
                issue      = 1'b1;
                state_next = TAIL;
            end
            TAIL: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            c_reg     <= '0;
            sub_reg   <= '0;
            tag_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (handshake) begin
                a_reg   <= opnd[0];
                b_reg   <= opnd[1];
                c_reg   <= opnd[2];
                sub_reg <= sub_vec;
                tag_reg <= grant[1];
            end
        end
    end

    assign bus.fma_issue = issue;
    assign bus.fma_a     = a_reg;
    assign bus.fma_b     = b_reg;
    assign bus.fma_c     = c_reg;
    assign bus.fma_sub   = sub_reg;

    // Tag shadow of the core pipeline; reset drops every in-flight tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_valid_reg <= '0;
            pipe_id_reg    <= '0;
        end else begin
            pipe_valid_reg[0] <= issue;
            pipe_id_reg[0]    <= tag_reg;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid_reg[i] <= pipe_valid_reg[i-1];
                pipe_id_reg[i]    <= pipe_id_reg[i-1];
            end
        end
    end

    assign bus.res_valid = pipe_valid_reg[LATENCY-1];
    assign bus.res_id    = pipe_id_reg[LATENCY-1];
    assign bus.res_data  = bus.fma_res;
endmodule

// File: tb/tb_fma_issue_ctrl.sv
// Directed + random bench for fma_issue_ctrl against a cycle-scheduled
// reference model (grant rules, earliest-next-handshake time, result calendar).
module tb_fma_issue_ctrl;
    localparam int L    = 4;
    localparam int NCYC = 2048;

    localparam logic [31:0] F_ONE   = 32'h3F80_0000;
    localparam logic [31:0] F_TWO   = 32'h4000_0000;
    localparam logic [31:0] F_THREE = 32'h4040_0000;
    localparam logic [31:0] F_INF   = 32'h7F80_0000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fma_issue_ctrl_if #(.WIDTH(32)) bus ();

    fma_issue_ctrl #(
        .WIDTH     (32),
        .EXP_WIDTH (8),
        .SIG_WIDTH (23),
        .LATENCY   (L)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: calendars indexed by absolute cycle number
    bit          exp_issue [NCYC];
    bit          exp_rv    [NCYC];
    bit          exp_rid   [NCYC];
    logic [31:0] m_a = '0, m_b = '0, m_c = '0;
    logic [2:0]  m_sub = '0;
    int          next_ok = 0;
    int          ptr = 0;

    function automatic bit is_sub(input logic [31:0] x);
        return (((x >> 23) & 32'hFF) == 32'd0) && ((x & 32'h007F_FFFF) != 32'd0);
    endfunction

    function automatic logic [31:0] rnd_norm();
        logic [31:0] x;
        x = $urandom;
        if (x[30:23] == 8'd0) x[30:23] = 8'h40;
        return x;
    endfunction

    function automatic logic [31:0] rnd_any();
        logic [31:0] x;
        x = $urandom;
        if ($urandom_range(0, 5) == 0) x = x & 32'h807F_FFFF;
        return x;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
        end
    endtask

    // One clock cycle: drive after the edge, compare at negedge, advance the model
    task automatic run_cycle(input bit v0, input bit v1,
                             input logic [31:0] a0, input logic [31:0] b0, input logic [31:0] c0,
                             input logic [31:0] a1, input logic [31:0] b1, input logic [31:0] c1,
                             input bit rst_low);
        int          g;
        logic [31:0] res_drv;
        res_drv        = $urandom;
        bus.req0_valid = v0;
        bus.req1_valid = v1;
        bus.req0_a     = a0;
        bus.req0_b     = b0;
        bus.req0_c     = c0;
        bus.req1_a     = a1;
        bus.req1_b     = b1;
        bus.req1_c     = c1;
        bus.fma_res    = res_drv;
        rst_n          = ~rst_low;
        if (rst_low) begin
            for (int k = cyc; k < NCYC; k++) begin
                exp_issue[k] = 1'b0;
                exp_rv[k]    = 1'b0;
            end
            m_a = '0; m_b = '0; m_c = '0; m_sub = '0;
            ptr = 0; next_ok = 0;
        end
        @(negedge clk);
        g = -1;
        if (!rst_low && cyc >= next_ok) begin
            if (v0 && v1) g = ptr;
            else if (v0) g = 0;
            else if (v1) g = 1;
        end
        check("req0_ready", 32'(bus.req0_ready), 32'(g == 0));
        check("req1_ready", 32'(bus.req1_ready), 32'(g == 1));
        check("fma_issue", 32'(bus.fma_issue), 32'(exp_issue[cyc]));
        check("fma_a", bus.fma_a, m_a);
        check("fma_b", bus.fma_b, m_b);
        check("fma_c", bus.fma_c, m_c);
        check("fma_sub", 32'(bus.fma_sub), 32'(m_sub));
        check("res_valid", 32'(bus.res_valid), 32'(exp_rv[cyc]));
        if (exp_rv[cyc]) begin
            check("res_id", 32'(bus.res_id), 32'(exp_rid[cyc]));
            check("res_data", bus.res_data, res_drv);
        end
        if (rst_low) check("res_id_rst", 32'(bus.res_id), 32'd0);
        if (g >= 0) begin
            m_a   = (g == 1) ? a1 : a0;
            m_b   = (g == 1) ? b1 : b0;
            m_c   = (g == 1) ? c1 : c0;
            m_sub = {is_sub(m_a), is_sub(m_b), is_sub(m_c)};
            exp_issue[cyc + 1]   = 1'b1;
            exp_rv[cyc + 1 + L]  = 1'b1;
            exp_rid[cyc + 1 + L] = g[0];
            next_ok = cyc + ((m_sub != 3'b000) ? 3 : 1);
            ptr     = 1 - g;
            $display("handshake cyc=%0d id=%0d a=%h b=%h c=%h sub=%b", cyc, g, m_a, m_b, m_c, m_sub);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle(0, 0, '0, '0, '0, '0, '0, '0, 0);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_a = '0; bus.req0_b = '0; bus.req0_c = '0;
        bus.req1_a = '0; bus.req1_b = '0; bus.req1_c = '0;
        bus.fma_res = '0;

        // Reset held with both requesters valid: no ready may leak out
        for (int i = 0; i < 3; i++)
            run_cycle(1, 1, F_ONE, F_TWO, F_THREE, F_ONE, F_TWO, F_THREE, 1);
        idle(10);

        // First triple from req0
        run_cycle(1, 0, F_ONE, F_TWO, F_THREE, '0, '0, '0, 0);
        idle(6);

        // Contention: grants alternate, issue every cycle
        for (int i = 0; i < 8; i++)
            run_cycle(1, 1, rnd_norm(), rnd_norm(), rnd_norm(), rnd_norm(), rnd_norm(), rnd_norm(), 0);
        idle(6);

        // Subnormal A from req1, req0 waits through HOLD and TAIL
        run_cycle(0, 1, '0, '0, '0, 32'h0000_0001, F_TWO, F_THREE, 0);
        for (int i = 0; i < 3; i++)
            run_cycle(1, 0, F_THREE, F_ONE, F_TWO, '0, '0, '0, 0);
        idle(6);

        // Zero and infinity are not subnormal: back-to-back issue
        run_cycle(1, 0, 32'h0000_0000, F_INF, F_ONE, '0, '0, '0, 0);
        run_cycle(1, 0, F_INF, 32'h0000_0000, 32'h8000_0000, '0, '0, '0, 0);
        idle(6);

        // Three in flight, then reset discards them and clears rr_ptr
        run_cycle(1, 0, rnd_norm(), rnd_norm(), rnd_norm(), '0, '0, '0, 0);
        run_cycle(0, 1, '0, '0, '0, rnd_norm(), rnd_norm(), rnd_norm(), 0);
        run_cycle(1, 0, rnd_norm(), rnd_norm(), rnd_norm(), '0, '0, '0, 0);
        run_cycle(0, 0, '0, '0, '0, '0, '0, '0, 1);
        run_cycle(0, 0, '0, '0, '0, '0, '0, '0, 1);
        run_cycle(1, 1, F_ONE, F_ONE, F_ONE, F_TWO, F_TWO, F_TWO, 0);
        // Lone req1 granted immediately regardless of pointer
        run_cycle(0, 1, '0, '0, '0, F_THREE, F_THREE, F_THREE, 0);
        run_cycle(0, 1, '0, '0, '0, F_TWO, F_ONE, F_THREE, 0);
        idle(8);

        // Random traffic with occasional subnormals and one mid-run reset
        for (int i = 0; i < 300; i++) begin
            run_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      rnd_any(), rnd_any(), rnd_any(), rnd_any(), rnd_any(), rnd_any(),
                      (i == 150));
        end
        idle(L + 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
